// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU between two requesters
module alu_share_arbiter #(
    parameter int N     = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [N-1:0]     req0_a,
    input  logic [N-1:0]     req0_b,
    input  logic [3:0]       req0_sel,
    input  logic [4:0]       req0_shamt,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [N-1:0]     req1_a,
    input  logic [N-1:0]     req1_b,
    input  logic [3:0]       req1_sel,
    input  logic [4:0]       req1_shamt,
    input  logic [TAG_W-1:0] req1_tag,

    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [3:0]       alu_sel,
    output logic [4:0]       alu_shamt,
    input  logic [N-1:0]     alu_result,
    input  logic             alu_cf,
    input  logic             alu_zf,
    input  logic             alu_vf,
    input  logic             alu_sf,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [N-1:0]     rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,

    output logic             busy
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    logic [1:0]       state_q,      state_d;
    // last_q = requester granted most recently; the other one wins a tie
    logic             last_q,       last_d;

    logic [N-1:0]     op_a_q,       op_a_d;
    logic [N-1:0]     op_b_q,       op_b_d;
    logic [3:0]       op_sel_q,     op_sel_d;
    logic [4:0]       op_shamt_q,   op_shamt_d;
    logic [TAG_W-1:0] op_tag_q,     op_tag_d;
    logic             op_id_q,      op_id_d;

    logic             rsp_valid_q,  rsp_valid_d;
    logic             rsp_id_q,     rsp_id_d;
    logic [TAG_W-1:0] rsp_tag_q,    rsp_tag_d;
    logic [N-1:0]     rsp_result_q, rsp_result_d;
    logic [3:0]       rsp_flags_q,  rsp_flags_d;
    logic             rsp_err_q,    rsp_err_d;

    logic             grant0;
    logic             grant1;
    logic             sel_legal;

    // Arbitration: only in IDLE; a tie goes to whoever was not served last
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                if (last_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    // Ready is the grant itself, gated low while reset is asserted
    assign req0_ready = grant0 & rst_n;
    assign req1_ready = grant1 & rst_n;

    // Decode of the select codes the ALU actually implements
    always_comb begin
        sel_legal = 1'b0;
        case (op_sel_q)
            4'b0000, 4'b0001, 4'b0100, 4'b0111,
            4'b1000, 4'b1001, 4'b1010, 4'b1101,
            4'b1111: sel_legal = 1'b1;
            default: sel_legal = 1'b0;
        endcase
    end

    // Next-state and datapath: latch winner in IDLE, capture ALU in EXEC, wait for handshake in RESP
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_sel_d     = op_sel_q;
        op_shamt_d   = op_shamt_q;
        op_tag_d     = op_tag_q;
        op_id_d      = op_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (grant0) begin
                    op_a_d     = req0_a;
                    op_b_d     = req0_b;
                    op_sel_d   = req0_sel;
                    op_shamt_d = req0_shamt;
                    op_tag_d   = req0_tag;
                    op_id_d    = 1'b0;
                    last_d     = 1'b0;
                    state_d    = ST_EXEC;
                end else if (grant1) begin
                    op_a_d     = req1_a;
                    op_b_d     = req1_b;
                    op_sel_d   = req1_sel;
                    op_shamt_d = req1_shamt;
                    op_tag_d   = req1_tag;
                    op_id_d    = 1'b1;
                    last_d     = 1'b1;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // An unsupported select still burns the EXEC cycle but reports a clean zero result
                rsp_valid_d = 1'b1;
                rsp_id_d    = op_id_q;
                rsp_tag_d   = op_tag_q;
                if (sel_legal) begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = {alu_cf, alu_zf, alu_vf, alu_sf};
                    rsp_err_d    = 1'b0;
                end else begin
                    rsp_result_d = '0;
                    rsp_flags_d  = 4'b0000;
                    rsp_err_d    = 1'b1;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight operation immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_q       <= 1'b1;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_sel_q     <= 4'b0000;
            op_shamt_q   <= 5'b00000;
            op_tag_q     <= '0;
            op_id_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= 4'b0000;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_sel_q     <= op_sel_d;
            op_shamt_q   <= op_shamt_d;
            op_tag_q     <= op_tag_d;
            op_id_q      <= op_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // ALU inputs come straight from the operand registers and keep their last values when idle
    assign alu_a      = op_a_q;
    assign alu_b      = op_b_q;
    assign alu_sel    = op_sel_q;
    assign alu_shamt  = op_shamt_q;

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;

    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - randomized and directed checks of alu_share_arbiter
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_sel, req1_sel;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [3:0]  req0_tag, req1_tag;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_sel;
    logic [4:0]  alu_shamt;
    logic        alu_cf, alu_zf, alu_vf, alu_sf;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [3:0]  rsp_tag, rsp_flags;
    logic [31:0] rsp_result;

    int total = 0;
    int bad   = 0;

    logic [41:0] rsp_bus;
    logic [35:0] alu_out;

    assign rsp_bus = {rsp_id, rsp_tag, rsp_result, rsp_flags, rsp_err};

    alu_share_arbiter #(.N(32), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_sel(req0_sel), .req0_shamt(req0_shamt), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sel(req1_sel), .req1_shamt(req1_shamt), .req1_tag(req1_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_cf(alu_cf), .alu_zf(alu_zf), .alu_vf(alu_vf), .alu_sf(alu_sf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: {cf,zf,vf,sf,result}; unsupported codes return junk so zeroing is observable
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] sel, input logic [4:0] sh);
        logic [32:0] w;
        logic [31:0] r;
        logic        cf, vf;
        cf = 1'b0; vf = 1'b0; r = '0; w = '0;
        case (sel)
            4'b0000: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; cf = w[32];
                           vf = (a[31] == b[31]) && (r[31] != a[31]); end
            4'b0001: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; cf = w[32];
                           vf = (a[31] != b[31]) && (r[31] != a[31]); end
            4'b0100: r = a | b;
            4'b0111: r = a ^ b;
            4'b1000: r = a & b;
            4'b1001: r = a << sh;
            4'b1010: r = a >> sh;
            4'b1101: r = $signed(a) >>> sh;
            4'b1111: r = b;
            default: return {4'b1111, a ^ b ^ 32'hDEAD_BEEF};
        endcase
        return {cf, (r == 32'h0), vf, r[31], r};
    endfunction

    always_comb alu_out = alu_fn(alu_a, alu_b, alu_sel, alu_shamt);
    assign {alu_cf, alu_zf, alu_vf, alu_sf, alu_result} = alu_out;

    function automatic logic is_legal(input logic [3:0] sel);
        return sel inside {4'b0000, 4'b0001, 4'b0100, 4'b0111, 4'b1000,
                           4'b1001, 4'b1010, 4'b1101, 4'b1111};
    endfunction

    // Expected response bundle {id,tag,result,flags,err} for one request
    function automatic logic [41:0] exp_rsp(input logic id, input logic [3:0] tag,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] sel, input logic [4:0] sh);
        logic [35:0] f;
        if (!is_legal(sel)) return {id, tag, 32'h0, 4'h0, 1'b1};
        f = alu_fn(a, b, sel, sh);
        return {id, tag, f[31:0], f[35:32], 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        req0_a = 32'h1234; req0_b = 32'h1; req0_sel = 4'b0000; req0_shamt = 5'd3; req0_tag = 4'h5;
        req1_a = 32'h9; req1_b = 32'h2; req1_sel = 4'b0001; req1_shamt = 5'd1; req1_tag = 4'h6;
        @(negedge clk);
        total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++;
            $display("FAIL reset_ready got=%b want=00", {req0_ready, req1_ready}); end
        total++; if ({rsp_valid, busy} !== 2'b00) begin bad++;
            $display("FAIL reset_valid_busy got=%b want=00", {rsp_valid, busy}); end
        total++; if (rsp_bus !== 42'h0) begin bad++;
            $display("FAIL reset_rsp got=%h want=0", rsp_bus); end
        total++; if ({alu_a, alu_b, alu_sel, alu_shamt} !== 73'h0) begin bad++;
            $display("FAIL reset_alu got=%h want=0", {alu_a, alu_b, alu_sel, alu_shamt}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_tie();
        do_reset();
        rsp_ready = 1'b1;
        req0_a = 32'hF0; req0_b = 32'h0F; req0_sel = 4'b0100; req0_shamt = 5'd0; req0_tag = 4'h3;
        req1_a = 32'h55; req1_b = 32'h55; req1_sel = 4'b0111; req1_shamt = 5'd0; req1_tag = 4'hC;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++;
            $display("FAIL tie_first_grant got=%b want=10", {req0_ready, req1_ready}); end
        tick(); req0_valid = 1'b0;
        @(negedge clk);
        total++; if ({req0_ready, req1_ready, busy, rsp_valid} !== 4'b0010) begin bad++;
            $display("FAIL tie_exec got=%b want=0010", {req0_ready, req1_ready, busy, rsp_valid}); end
        tick();
        @(negedge clk);
        total++; if ({rsp_valid, rsp_bus} !== {1'b1, 1'b0, 4'h3, 32'hFF, 4'b0000, 1'b0}) begin bad++;
            $display("FAIL tie_rsp0 got=%h want=%h", {rsp_valid, rsp_bus}, {1'b1, 1'b0, 4'h3, 32'hFF, 4'b0000, 1'b0}); end
        tick();
        @(negedge clk);
        total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++;
            $display("FAIL tie_second_grant got=%b want=01", {req0_ready, req1_ready}); end
        tick(); req1_valid = 1'b0;
        tick();
        @(negedge clk);
        total++; if ({rsp_valid, rsp_bus} !== {1'b1, 1'b1, 4'hC, 32'h0, 4'b0100, 1'b0}) begin bad++;
            $display("FAIL tie_rsp1 got=%h want=%h", {rsp_valid, rsp_bus}, {1'b1, 1'b1, 4'hC, 32'h0, 4'b0100, 1'b0}); end
        tick();
        @(negedge clk);
        total++; if ({rsp_valid, busy} !== 2'b00) begin bad++;
            $display("FAIL tie_done got=%b want=00", {rsp_valid, busy}); end
    endtask

    task automatic test_single();
        do_reset();
        rsp_ready = 1'b1;
        req0_a = 32'd5; req0_b = 32'd3; req0_sel = 4'b0001; req0_shamt = 5'd0; req0_tag = 4'hA;
        req0_valid = 1'b1;
        @(negedge clk);
        total++; if (req0_ready !== 1'b1) begin bad++;
            $display("FAIL single_ready got=%b want=1", req0_ready); end
        tick(); req0_valid = 1'b0;
        @(negedge clk);
        total++; if ({req0_ready, rsp_valid, busy, alu_a, alu_b, alu_sel} !== {3'b001, 32'd5, 32'd3, 4'b0001}) begin bad++;
            $display("FAIL single_exec got=%h want=%h", {req0_ready, rsp_valid, busy, alu_a, alu_b, alu_sel}, {3'b001, 32'd5, 32'd3, 4'b0001}); end
        tick();
        @(negedge clk);
        total++; if ({rsp_valid, rsp_bus} !== {1'b1, 1'b0, 4'hA, 32'd2, 4'b0000, 1'b0}) begin bad++;
            $display("FAIL single_rsp got=%h want=%h", {rsp_valid, rsp_bus}, {1'b1, 1'b0, 4'hA, 32'd2, 4'b0000, 1'b0}); end
        tick();
        @(negedge clk);
        total++; if ({rsp_valid, busy, alu_a} !== {2'b00, 32'd5}) begin bad++;
            $display("FAIL single_after got=%h want=%h", {rsp_valid, busy, alu_a}, {2'b00, 32'd5}); end
    endtask

    task automatic test_fairness();
        logic        w;
        logic [41:0] exp;
        int          cnt;
        do_reset();
        rsp_ready = 1'b1;
        req0_a = 32'h100; req0_b = 32'h1; req0_sel = 4'b0000; req0_shamt = 5'd0; req0_tag = 4'h0;
        req1_a = 32'h200; req1_b = 32'h2; req1_sel = 4'b0001; req1_shamt = 5'd0; req1_tag = 4'h8;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cnt = 0;
            do begin @(negedge clk); cnt++; end while (!req0_ready && !req1_ready && cnt < 10);
            w = req1_ready;
            total++; if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin bad++;
                $display("FAIL fair_grant_%0d got=%b want=%b", k, {req0_ready, req1_ready}, (k % 2 == 0) ? 2'b10 : 2'b01); end
            if (w) exp = exp_rsp(1'b1, req1_tag, req1_a, req1_b, req1_sel, req1_shamt);
            else   exp = exp_rsp(1'b0, req0_tag, req0_a, req0_b, req0_sel, req0_shamt);
            tick();
            if (w) begin req1_tag = req1_tag + 4'h1; req1_a = req1_a + 32'h11; end
            else   begin req0_tag = req0_tag + 4'h1; req0_a = req0_a + 32'h7;  end
            cnt = 0;
            do begin @(negedge clk); cnt++; end while (!rsp_valid && cnt < 10);
            total++; if ({rsp_valid, rsp_bus} !== {1'b1, exp}) begin bad++;
                $display("FAIL fair_rsp_%0d got=%h want=%h", k, {rsp_valid, rsp_bus}, {1'b1, exp}); end
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_backpressure();
        logic [41:0] exp, snap;
        do_reset();
        req0_a = 32'h7FFF_FFFF; req0_b = 32'h1; req0_sel = 4'b0000; req0_shamt = 5'd0; req0_tag = 4'h9;
        req1_a = 32'h8; req1_b = 32'h0; req1_sel = 4'b1001; req1_shamt = 5'd4; req1_tag = 4'h2;
        exp = exp_rsp(1'b0, 4'h9, 32'h7FFF_FFFF, 32'h1, 4'b0000, 5'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        tick(); req0_valid = 1'b0;
        tick();
        @(negedge clk);
        snap = rsp_bus;
        total++; if ({rsp_valid, snap} !== {1'b1, exp}) begin bad++;
            $display("FAIL bp_rsp got=%h want=%h", {rsp_valid, snap}, {1'b1, exp}); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if ({rsp_valid, busy, req0_ready, req1_ready, rsp_bus} !== {4'b1100, snap}) begin bad++;
                $display("FAIL bp_hold_%0d got=%h want=%h", i, {rsp_valid, busy, req0_ready, req1_ready, rsp_bus}, {4'b1100, snap}); end
        end
        tick(); rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        total++; if ({rsp_valid, busy, req1_ready} !== 3'b001) begin bad++;
            $display("FAIL bp_release got=%b want=001", {rsp_valid, busy, req1_ready}); end
        tick(); req1_valid = 1'b0;
        tick();
        @(negedge clk);
        total++; if ({rsp_valid, rsp_bus} !== {1'b1, exp_rsp(1'b1, 4'h2, 32'h8, 32'h0, 4'b1001, 5'd4)}) begin bad++;
            $display("FAIL bp_drain got=%h want=%h", {rsp_valid, rsp_bus}, {1'b1, exp_rsp(1'b1, 4'h2, 32'h8, 32'h0, 4'b1001, 5'd4)}); end
        repeat (2) tick();
    endtask

    task automatic test_illegal();
        do_reset();
        rsp_ready = 1'b1;
        req1_a = 32'h1234_5678; req1_b = 32'h0F0F_0F0F; req1_sel = 4'b0010; req1_shamt = 5'd2; req1_tag = 4'hE;
        req1_valid = 1'b1;
        @(negedge clk);
        total++; if (req1_ready !== 1'b1) begin bad++;
            $display("FAIL illegal_ready got=%b want=1", req1_ready); end
        tick(); req1_valid = 1'b0;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++;
            $display("FAIL illegal_early got=%b want=0", rsp_valid); end
        tick();
        @(negedge clk);
        total++; if ({rsp_valid, rsp_bus} !== {1'b1, 1'b1, 4'hE, 32'h0, 4'h0, 1'b1}) begin bad++;
            $display("FAIL illegal_rsp got=%h want=%h", {rsp_valid, rsp_bus}, {1'b1, 1'b1, 4'hE, 32'h0, 4'h0, 1'b1}); end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsp_ready = 1'b1;
        req0_a = 32'hABCD; req0_b = 32'h11; req0_sel = 4'b1000; req0_shamt = 5'd7; req0_tag = 4'h4;
        req0_valid = 1'b1;
        tick(); req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if ({rsp_valid, busy, alu_a, alu_b, alu_sel, alu_shamt} !== 75'h0) begin bad++;
            $display("FAIL midrst_async got=%h want=0", {rsp_valid, busy, alu_a, alu_b, alu_sel, alu_shamt}); end
        @(negedge clk);
        total++; if ({rsp_valid, busy} !== 2'b00) begin bad++;
            $display("FAIL midrst_hold got=%b want=00", {rsp_valid, busy}); end
        @(posedge clk); #1;
        req1_a = 32'h3; req1_b = 32'h4; req1_sel = 4'b0000; req1_shamt = 5'd0; req1_tag = 4'h1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++;
            $display("FAIL midrst_tie got=%b want=10", {req0_ready, req1_ready}); end
        tick(); req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_random(input int n_ops);
        logic        pend[2];
        logic [31:0] ra[2], rb[2];
        logic [3:0]  rsel[2], rtag[2];
        logic [4:0]  rsh[2];
        logic [3:0]  legal_ops[9];
        logic        mlast, inflight, eg0, eg1, erv;
        logic [41:0] exp_cur;
        int          acc_cyc, cyc, done;
        legal_ops = '{4'b0000, 4'b0001, 4'b0100, 4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1101, 4'b1111};
        do_reset();
        mlast = 1'b1; inflight = 1'b0; acc_cyc = 0; cyc = 0; done = 0; exp_cur = '0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        while (done < n_ops && cyc < 4000) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1'b1;
                    ra[r] = $urandom; rb[r] = ($urandom_range(0, 3) == 0) ? ra[r] : $urandom;
                    rsel[r] = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 8)];
                    rsh[r] = 5'($urandom); rtag[r] = 4'($urandom);
                end
            end
            req0_valid = pend[0]; req0_a = ra[0]; req0_b = rb[0]; req0_sel = rsel[0]; req0_shamt = rsh[0]; req0_tag = rtag[0];
            req1_valid = pend[1]; req1_a = ra[1]; req1_b = rb[1]; req1_sel = rsel[1]; req1_shamt = rsh[1]; req1_tag = rtag[1];
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            eg0 = !inflight && pend[0] && (!pend[1] || mlast);
            eg1 = !inflight && pend[1] && (!pend[0] || !mlast);
            erv = inflight && (cyc - acc_cyc >= 2);
            total++; if ({req0_ready, req1_ready, rsp_valid} !== {eg0, eg1, erv}) begin bad++;
                $display("FAIL rand_ctrl cyc=%0d got=%b want=%b", cyc, {req0_ready, req1_ready, rsp_valid}, {eg0, eg1, erv}); end
            if (erv && rsp_valid) begin
                total++; if (rsp_bus !== exp_cur) begin bad++;
                    $display("FAIL rand_rsp cyc=%0d got=%h want=%h", cyc, rsp_bus, exp_cur); end
            end
            if (eg0 || eg1) begin
                inflight = 1'b1; acc_cyc = cyc; mlast = eg1;
                exp_cur = exp_rsp(eg1, rtag[eg1], ra[eg1], rb[eg1], rsel[eg1], rsh[eg1]);
                pend[eg1] = 1'b0;
            end else if (erv && rsp_ready) begin
                inflight = 1'b0; done++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        total++; if (done < n_ops) begin bad++;
            $display("FAIL rand_timeout got=%0d want=%0d", done, n_ops); end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_sel = '0; req0_shamt = '0; req0_tag = '0;
        req1_a = '0; req1_b = '0; req1_sel = '0; req1_shamt = '0; req1_tag = '0;
        test_reset();
        test_tie();
        test_single();
        test_fairness();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_random(80);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one ALU instance between two requesters: the execute-stage issue port (requester 0) and the branch/address helper port (requester 1). Each requester presents an operation over a valid/ready handshake. The block arbitrates round-robin, drives the ALU operand/select inputs from registered copies, and captures result and flags. It returns them on a single valid/ready response channel tagged with the winning requester and its tag.

## Interface
- N, 32, datapath width (ALU operand/result width)
- TAG_W, 4, width of requester-supplied transaction tag

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid / req1_valid  in  1  requester has an operation
- req0_ready / req1_ready  out  1  operation accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  N  operands
- req0_sel / req1_sel  in  4  ALU operation select
- req0_shamt / req1_shamt  in  5  shift amount
- req0_tag / req1_tag  in  TAG_W  opaque tag, returned with response
- alu_a, alu_b  out  N  ALU operand inputs
- alu_sel  out  4  ALU select
- alu_shamt  out  5  ALU shift amount
- alu_result  in  N  ALU result (combinational from alu_* outputs)
- alu_cf, alu_zf, alu_vf, alu_sf  in  1  ALU flags
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued this response (0/1)
- rsp_tag  out  TAG_W  tag of that request
- rsp_result  out  N  captured result (0 when rsp_err)
- rsp_flags  out  4  {cf,zf,vf,sf} captured
- rsp_err  out  1  request used an unsupported sel code
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no req valid, stay.
  - If exactly one valid, grant it.
  - If both valid, grant the requester not granted last (round-robin pointer `last`).
  - Grant asserts that requester's ready combinationally in IDLE only. It latches a/b/sel/shamt/tag/id into operand registers, updates `last`, and moves to EXEC.
- req*_ready is 0 in EXEC and RESP; the non-granted requester sees ready=0 and must hold its request.
- EXEC: the operand registers drive alu_a/b/sel/shamt. At the end of the cycle, capture alu_result and flags into the response registers, set rsp_valid, and move to RESP.
- Legal sel codes: 0000, 0001, 0100, 0111, 1000, 1001, 1010, 1101, 1111. Any other code still takes the EXEC cycle, but captures rsp_err=1, rsp_result=0, and rsp_flags=0000.
- RESP: hold all rsp_* stable while rsp_valid & !rsp_ready. On rsp_valid & rsp_ready, clear rsp_valid and go to IDLE.
- alu_* outputs always reflect the operand registers. They hold their last values after completion and are not zeroed in IDLE.
- No operation is dropped or duplicated. Responses return in grant order; there is one transaction in flight at most.

## Timing
- Reset (async assert, sync-safe deassert by upstream):
  - State = IDLE.
  - All outputs low: req*_ready=0 until the first IDLE evaluation, rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_result=0, rsp_flags=0, rsp_err=0, busy=0, alu_a=alu_b=0, alu_sel=0, alu_shamt=0.
  - last=1, so requester 0 wins the first tie.
- Accept at edge T (valid&ready high). EXEC during cycle T+1, with alu_* updated from edge T. Capture at edge T+1; rsp_valid high from cycle T+2.
- Request-to-response latency is 2 cycles.
- Earliest next accept is the cycle after the rsp handshake, giving a minimum of 3 cycles per operation with rsp_ready held high.
- Simultaneous valid from both requesters: only one ready is asserted per cycle.
- A requester dropping valid before being granted: no grant, no state change. The protocol forbids this, but the block must tolerate it.
- rst_n asserted in any state, including mid-EXEC or with rsp_valid pending: the in-flight operation is discarded and all outputs return to reset values immediately (asynchronous).

## Test plan
- Single op: req0 a=5, b=3, sel=0001, tag=0xA -> req0_ready high one cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_tag=0xA, rsp_result=2, zf=0.
- Tie: both valid at the first cycle after reset (req0 sel=0100, a=0xF0, b=0x0F; req1 sel=0111, a=b=0x55) -> req0 is served first (result 0xFF). Then req1 is served (result 0, zf=1, rsp_id=1).
- Fairness: both valid continuously for 6 operations -> grants alternate 0,1,0,1,0,1, and each response carries the matching tag.
- Backpressure: hold rsp_ready=0 for 5 cycles with a response pending -> rsp_* remains bit-stable, both req*_ready stay 0, and busy=1. Release -> one handshake, then IDLE.
- Illegal sel: req1 sel=0010 -> rsp_err=1, rsp_result=0, rsp_flags=0, with 2-cycle latency unchanged.
- Reset mid-operation: assert rst_n=0 during EXEC -> rsp_valid stays 0, busy=0, and alu_* return to 0. After release, a tie goes to requester 0.
